// File: rtl/ucsbece154b_fifo_arb_pkg.sv
// Shared types and constants for the two-producer FIFO push arbiter.
package ucsbece154b_fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

  // Beat counter width; a one-beat burst still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    if (burst_len > 32'd1) begin
      return $clog2(burst_len);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/ucsbece154b_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// on contention the producer named by prio wins.
module ucsbece154b_rr_pick2
  import ucsbece154b_fifo_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       win,
  output logic       any
);

  // Select the winner from the request pattern and current priority.
  always_comb begin
    win = OWNER_0;
    any = |req;
    case (req)
      2'b01:   win = OWNER_0;
      2'b10:   win = OWNER_1;
      2'b11:   win = prio;
      default: win = OWNER_0;
    endcase
  end

endmodule

// File: rtl/ucsbece154b_fifo_push_arb.sv
// Round-robin burst arbiter sharing one FIFO push port between two producers.
// A winner owns the port for exactly BURST_LEN accepted beats; priority then
// rotates to the other producer. flush_i aborts a burst without rotating.
module ucsbece154b_fifo_push_arb
  import ucsbece154b_fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  valid0_i,
  input  logic                  valid1_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  ready0_o,
  output logic                  ready1_o,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  fifo_push_o,
  input  logic                  fifo_full_i,
  output logic                  busy_o,
  output logic                  burst_done_o
);

  localparam int unsigned      CNT_W    = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;

  logic             pick_win_s;
  logic             pick_any_s;
  logic             beat_ok_s;
  logic             own_valid_s;

  ucsbece154b_rr_pick2 u_pick (
    .req  ({req1_i, req0_i}),
    .prio (prio_q),
    .win  (pick_win_s),
    .any  (pick_any_s)
  );

  // Next-state, beat counting and the combinational handshake outputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    ready0_o     = 1'b0;
    ready1_o     = 1'b0;
    fifo_push_o  = 1'b0;
    fifo_data_o  = {DATA_WIDTH{1'b0}};
    burst_done_o = 1'b0;
    beat_ok_s    = 1'b0;
    own_valid_s  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (flush_i) begin
          state_d = ARB_IDLE;
        end else if (pick_any_s) begin
          state_d = ARB_BURST;
          owner_d = pick_win_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        // Full is honoured even if the FIFO pops this cycle: never push-while-full.
        beat_ok_s   = !fifo_full_i && !flush_i;
        ready0_o    = (owner_q == OWNER_0) && beat_ok_s;
        ready1_o    = (owner_q == OWNER_1) && beat_ok_s;
        own_valid_s = (owner_q == OWNER_1) ? valid1_i : valid0_i;
        fifo_data_o = (owner_q == OWNER_1) ? data1_i : data0_i;
        fifo_push_o = own_valid_s && beat_ok_s;
        if (flush_i) begin
          state_d = ARB_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (fifo_push_o) begin
          if (cnt_q == CNT_LAST) begin
            burst_done_o = 1'b1;
            state_d      = ARB_IDLE;
            cnt_d        = {CNT_W{1'b0}};
            prio_d       = !owner_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ARB_BURST);
    gnt0_d = busy_d && (owner_d == OWNER_0);
    gnt1_d = busy_d && (owner_d == OWNER_1);
  end

  // State, ownership, priority and registered grant/busy flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_0;
      prio_q  <= OWNER_0;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  assign busy_o = busy_q;
  assign gnt0_o = gnt0_q;
  assign gnt1_o = gnt1_q;

endmodule

// File: tb/tb_ucsbece154b_fifo_push_arb.sv
// Scoreboard bench for the FIFO push arbiter: the stimulus process queues the
// beats it expects to see pushed; a monitor pops and compares on every push.
module tb_ucsbece154b_fifo_push_arb;

  logic        clk;
  logic        rst_ni;
  logic        flush_i;
  logic        req0_i, req1_i;
  logic        valid0_i, valid1_i;
  logic [31:0] data0_i, data1_i;
  logic        ready0_o, ready1_o;
  logic        gnt0_o, gnt1_o;
  logic [31:0] fifo_data_o;
  logic        fifo_push_o;
  logic        fifo_full_i;
  logic        busy_o;
  logic        burst_done_o;

  typedef struct packed {
    logic [31:0] data;
    logic        owner;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] base0, base1;
  logic [31:0] idx0, idx1;
  logic        acc0, acc1;

  assign data0_i = base0 + idx0;
  assign data1_i = base1 + idx1;

  ucsbece154b_fifo_push_arb #(.DATA_WIDTH(32), .BURST_LEN(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .req0_i       (req0_i),
    .req1_i       (req1_i),
    .valid0_i     (valid0_i),
    .valid1_i     (valid1_i),
    .data0_i      (data0_i),
    .data1_i      (data1_i),
    .ready0_o     (ready0_o),
    .ready1_o     (ready1_o),
    .gnt0_o       (gnt0_o),
    .gnt1_o       (gnt1_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_push_o  (fifo_push_o),
    .fifo_full_i  (fifo_full_i),
    .busy_o       (busy_o),
    .burst_done_o (burst_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_beats(input logic [31:0] base, input int n, input logic owner);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: base + 32'(i), owner: owner, done: (i == 3)});
    end
  endtask

  // Go to the falling edge and note which producer beats are accepted.
  task automatic to_neg();
    @(negedge clk);
    acc0 = valid0_i & ready0_o;
    acc1 = valid1_i & ready1_o;
  endtask

  // Cross the rising edge; producers advance to their next beat if accepted.
  task automatic to_post();
    @(posedge clk);
    #1;
    if (acc0) idx0 = idx0 + 32'd1;
    if (acc1) idx1 = idx1 + 32'd1;
  endtask

  task automatic cyc();
    to_neg();
    to_post();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_gnt"},   {30'd0, gnt1_o, gnt0_o}, 32'd0);
    chk({name, "_busy"},  {31'd0, busy_o}, 32'd0);
    chk({name, "_push"},  {30'd0, fifo_push_o, burst_done_o}, 32'd0);
    chk({name, "_ready"}, {30'd0, ready1_o, ready0_o}, 32'd0);
    chk({name, "_data"},  fifo_data_o, 32'd0);
  endtask

  // Monitor: every push must match the head of the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_push_o) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_push: got push of %h, expected no push (t=%0t)", fifo_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("push_data",  fifo_data_o, e.data);
          chk("push_done",  {31'd0, burst_done_o}, {31'd0, e.done});
          chk("push_gnt",   {30'd0, gnt1_o, gnt0_o}, e.owner ? 32'd2 : 32'd1);
          chk("push_ready", {31'd0, (e.owner ? ready1_o : ready0_o)}, 32'd1);
        end
      end else if (burst_done_o) begin
        total_cnt++;
        $display("FAIL done_without_push: got burst_done=1, expected 0 (t=%0t)", $time);
      end
    end
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; fifo_full_i = 1'b0;
    req0_i = 1'b0; req1_i = 1'b0; valid0_i = 1'b0; valid1_i = 1'b0;
    base0 = 32'd0; base1 = 32'd0; idx0 = 32'd0; idx1 = 32'd0;
    acc0 = 1'b0; acc1 = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    cyc();

    // Single burst from producer 0: A0..A3.
    req0_i = 1'b1; valid0_i = 1'b1; base0 = 32'hA0; idx0 = 32'd0;
    expect_beats(32'hA0, 4, 1'b0);
    chk("t1_gnt_before", {31'd0, gnt0_o}, 32'd0);
    cyc();
    chk("t1_gnt0", {31'd0, gnt0_o}, 32'd1);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    req0_i = 1'b0;
    cyc(); cyc(); cyc();
    chk("t1_busy_last", {31'd0, busy_o}, 32'd1);
    cyc();
    chk("t1_busy_fall", {31'd0, busy_o}, 32'd0);
    valid0_i = 1'b0;

    // Contention: priority is now 1, so grants run 1,0,1,0 with one bubble each.
    base0 = 32'h100; idx0 = 32'd0; base1 = 32'h200; idx1 = 32'd0;
    req0_i = 1'b1; req1_i = 1'b1; valid0_i = 1'b1; valid1_i = 1'b1;
    expect_beats(32'h200, 4, 1'b1);
    expect_beats(32'h100, 4, 1'b0);
    expect_beats(32'h204, 4, 1'b1);
    expect_beats(32'h104, 4, 1'b0);
    cyc();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_gnt", {30'd0, gnt1_o, gnt0_o}, (b % 2 == 0) ? 32'd2 : 32'd1);
        cyc();
      end
      chk("t2_bubble", {30'd0, gnt1_o, busy_o}, 32'd0);
      if (b == 3) begin
        req0_i = 1'b0; req1_i = 1'b0;
      end
      cyc();
    end
    valid0_i = 1'b0; valid1_i = 1'b0;

    // Backpressure: owner 1, full for 3 cycles after two beats.
    base1 = 32'h300; idx1 = 32'd0; req1_i = 1'b1; valid1_i = 1'b1;
    expect_beats(32'h300, 4, 1'b1);
    cyc();
    chk("t3_gnt1", {31'd0, gnt1_o}, 32'd1);
    req1_i = 1'b0;
    cyc(); cyc();
    fifo_full_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("t3_full_ready1", {31'd0, ready1_o}, 32'd0);
      chk("t3_full_push", {31'd0, fifo_push_o}, 32'd0);
      to_post();
    end
    fifo_full_i = 1'b0;
    chk("t3_busy_held", {31'd0, busy_o}, 32'd1);
    cyc(); cyc();
    chk("t3_busy_fall", {31'd0, busy_o}, 32'd0);
    valid1_i = 1'b0;

    // Flush after two beats; priority (0) must be unchanged afterwards.
    base0 = 32'h400; idx0 = 32'd0; valid0_i = 1'b1;
    req0_i = 1'b1; req1_i = 1'b1;
    expect_beats(32'h400, 2, 1'b0);
    cyc();
    chk("t4_gnt0", {30'd0, gnt1_o, gnt0_o}, 32'd1);
    cyc(); cyc();
    flush_i = 1'b1;
    to_neg();
    chk("t4_flush_push", {30'd0, fifo_push_o, burst_done_o}, 32'd0);
    chk("t4_flush_ready", {30'd0, ready1_o, ready0_o}, 32'd0);
    to_post();
    flush_i = 1'b0;
    chk("t4_idle", {31'd0, busy_o}, 32'd0);
    exp_q.push_back('{data: 32'h402, owner: 1'b0, done: 1'b0});
    exp_q.push_back('{data: 32'h403, owner: 1'b0, done: 1'b0});
    exp_q.push_back('{data: 32'h404, owner: 1'b0, done: 1'b0});
    exp_q.push_back('{data: 32'h405, owner: 1'b0, done: 1'b1});
    cyc();
    chk("t4_regrant", {30'd0, gnt1_o, gnt0_o}, 32'd1);
    req0_i = 1'b0; req1_i = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    valid0_i = 1'b0;

    // Non-owner presents 0xDEAD; owner drops its request mid-burst.
    base0 = 32'h500; idx0 = 32'd0; base1 = 32'hDEAD; idx1 = 32'd0;
    req0_i = 1'b1; valid0_i = 1'b1; valid1_i = 1'b1;
    expect_beats(32'h500, 4, 1'b0);
    cyc();
    cyc();
    req0_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("t5_ready1", {31'd0, ready1_o}, 32'd0);
      chk("t5_gnt0_held", {31'd0, gnt0_o}, 32'd1);
      to_post();
    end
    chk("t5_busy_fall", {31'd0, busy_o}, 32'd0);
    valid0_i = 1'b0; valid1_i = 1'b0;

    // Asynchronous reset mid-burst.
    base0 = 32'h600; idx0 = 32'd0; req0_i = 1'b1; valid0_i = 1'b1;
    exp_q.push_back('{data: 32'h600, owner: 1'b0, done: 1'b0});
    exp_q.push_back('{data: 32'h601, owner: 1'b0, done: 1'b0});
    cyc(); cyc(); cyc();
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("async_rst");
    req0_i = 1'b0; valid0_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    base1 = 32'h700; idx1 = 32'd0; req1_i = 1'b1; valid1_i = 1'b1;
    expect_beats(32'h700, 4, 1'b1);
    cyc();
    chk("t6_gnt1", {30'd0, gnt1_o, gnt0_o}, 32'd2);
    base0 = 32'h800; idx0 = 32'd0; req0_i = 1'b1; valid0_i = 1'b1;
    expect_beats(32'h800, 4, 1'b0);
    cyc(); cyc(); cyc(); cyc();
    chk("t6_bubble", {31'd0, busy_o}, 32'd0);
    cyc();
    chk("t6_contention_gnt0", {30'd0, gnt1_o, gnt0_o}, 32'd1);
    req0_i = 1'b0; req1_i = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    valid0_i = 1'b0; valid1_i = 1'b0;

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      cyc();
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_fifo_push_arb.md
# ucsbece154b_fifo_push_arb

Round-robin burst arbiter that shares the push port of one `ucsbece154b_fifo` instance between two producers, for example the instruction-refill and data-refill paths. A producer requests, receives a grant for exactly `BURST_LEN` beats, and streams its data into the FIFO under full-flag backpressure. On the last beat the grant is released and priority rotates to the other producer. The block sits between the producers and the FIFO's `data_i`/`push_i`/`full_o` pins.

## Interface
- `DATA_WIDTH`, 32: width of each beat and of the FIFO data port.
- `BURST_LEN`, 4: beats per grant; must be ≥ 1.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, **asynchronous, active-low**.
- `flush_i` in 1: synchronous abort of the current burst.
- `req0_i`, `req1_i` in 1: producer N requests a burst (level).
- `valid0_i`, `valid1_i` in 1: producer N presents a beat.
- `data0_i`, `data1_i` in `DATA_WIDTH`: producer N beat data.
- `ready0_o`, `ready1_o` out 1: beat from producer N accepted this cycle.
- `gnt0_o`, `gnt1_o` out 1: producer N owns the FIFO (registered).
- `fifo_data_o` out `DATA_WIDTH`: to FIFO `data_i`.
- `fifo_push_o` out 1: to FIFO `push_i`.
- `fifo_full_i` in 1: from FIFO `full_o`.
- `busy_o` out 1: a burst is in progress.
- `burst_done_o` out 1: pulses on the accepted last beat of a burst.

## Operation
- FSM states: `ARB_IDLE` and `ARB_BURST`. Registers: state, `owner_q` (1 bit), `prio_q` (1 bit), beat count `cnt_q` (width `max(1,$clog2(BURST_LEN))`).
- In `ARB_IDLE`:
  - If only one request is high, that producer wins.
  - If both are high, producer `prio_q` wins.
  - The winner is loaded into `owner_q`, `cnt_q`←0, and the FSM moves to `ARB_BURST` next cycle.
  - With no request, the FSM stays in `ARB_IDLE`.
- In `ARB_BURST`:
  - `readyN_o` = (`owner_q`==N) && !`fifo_full_i` && !`flush_i`.
  - `fifo_push_o` = `valid[owner_q]` && `ready[owner_q]`.
  - `fifo_data_o` = `data[owner_q]` (combinational mux). When there is no push, `fifo_data_o` holds the owner's data; this is don't-care.
- Each push increments `cnt_q`. A push with `cnt_q`==`BURST_LEN`-1 is the last beat:
  - `burst_done_o`=1.
  - Next state is `ARB_IDLE` with `cnt_q`←0.
  - `prio_q`←!`owner_q`.
- Backpressure: while `fifo_full_i`=1, no push occurs, `readyN_o`=0 and `cnt_q` holds. Push-while-full is never issued, even if the consumer pops in the same cycle.
- Requests are ignored in `ARB_BURST`. If the owner deasserts `reqN_i`, the grant is still held until the burst completes or is flushed.
- The non-owner's `valid` and `data` are ignored; its `ready` stays 0.
- `flush_i`=1:
  - Forces `fifo_push_o`=0 and both readys to 0 that cycle.
  - Next state is `ARB_IDLE`, `cnt_q`←0.
  - `prio_q` is unchanged and no `burst_done_o` is raised.
  - In `ARB_IDLE`, flush blocks arbitration for that cycle.
- Reset (async assert, any time, including mid-burst): state `ARB_IDLE`, `owner_q`=0, `prio_q`=0, `cnt_q`=0. All outputs are 0, including `fifo_data_o`. Beats already pushed remain in the FIFO; the FIFO has its own reset.

## Timing
- Request to grant: a request sampled in `ARB_IDLE` at cycle t gives `gntN_o`=1 and `busy_o`=1 at t+1. The first push can occur at t+1.
- No-stall burst: pushes at t+1…t+`BURST_LEN`. The FSM is back in `ARB_IDLE` at t+`BURST_LEN`+1, and the next grant comes no earlier than t+`BURST_LEN`+2. There is exactly one idle bubble between bursts.
- `gntN_o` and `busy_o` are registered.
- `readyN_o`, `fifo_push_o`, `fifo_data_o` and `burst_done_o` are combinational from registers plus `valid`/`full`/`flush`.
- `BURST_LEN`=1: every grant is a single beat, and `cnt_q` stays 0.

## Structure
- Package `ucsbece154b_fifo_arb_pkg`:
  - enum `arb_state_e` {`ARB_IDLE`, `ARB_BURST`}.
  - localparams `OWNER_0`=1'b0, `OWNER_1`=1'b1.
- Sub-module `ucsbece154b_rr_pick2`: combinational 2-way round-robin picker. Inputs are `req[1:0]` and `prio`; outputs are `win` and `any`. The counter and FSM are inline in the top.

## Test plan
- Reset, then `req0_i`=1 with `valid0_i` held high, `BURST_LEN`=4, data 0xA0…0xA3 → `gnt0_o` rises 1 cycle later. Four consecutive pushes of 0xA0–0xA3 follow, `burst_done_o` pulses on 0xA3, and `busy_o` falls the cycle after.
- Both requests held high continuously → grants alternate 0,1,0,1. There is exactly one idle cycle between bursts, and each burst is exactly 4 pushes.
- Owner 1 mid-burst (`cnt_q`=2), `fifo_full_i`=1 for 3 cycles → no push and `ready1_o`=0 for those cycles. The remaining 2 beats complete after full deasserts, and the total stays at 4.
- `flush_i` pulsed after 2 of 4 beats → no push in the flush cycle, `ARB_IDLE` next cycle, no `burst_done_o`. With both requests high afterwards, the grant goes to the same `prio_q` as before the flush.
- Non-owner asserts `valid1_i` with data 0xDEAD during producer 0's burst → 0xDEAD is never pushed and `ready1_o` stays 0. `req0_i` dropped mid-burst → the grant is held until the 4th beat.
- `rst_ni` asserted asynchronously mid-burst → all outputs go to 0 immediately. After release, `req1_i` alone is granted to 1, and on the next contention 0 wins (`prio_q` was reset to 0, then set to 0 again when producer 1's burst completed).
